mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multi-cycle MIPS main control unit; the successor to the single-cycle combinational decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the shared-datapath muxes and enables.
- Supports a variable-latency memory through a ready handshake with a timeout.
- Sits between the instruction register and the shared ALU/memory/register-file datapath.

Parameters:
- USE_MEM_READY, 1, 1: memory states wait for mem_ready; 0: memory states are fixed single-cycle and mem_ready is ignored.
- MEM_TIMEOUT, 16, maximum wait cycles in any memory state before a bus-error trap; range 1..255.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- instruction31_26  in  6  opcode field from the instruction register
- instruction5_0  in  6  funct field from the instruction register
- mem_ready  in  1  memory access complete this cycle
- alu_control  out  t_alu_opcode  ALU operation
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load qualified by ALU zero (BEQ)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- MemToReg  out  1  write-back data select: 0 = ALUOut, 1 = MDR
- RegDst  out  1  destination select: 0 = rt, 1 = rd
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A register
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted immediate
- PCSource  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
- illegal_instr  out  1  one-cycle pulse on undecodable opcode/funct
- bus_error  out  1  one-cycle pulse on memory timeout
- instr_retired  out  1  one-cycle pulse when an instruction completes
- retired_count  out  CNT_W  count of retired instructions; wraps
- state_o  out  t_mc_state  current state, for debug

Behaviour:
- Clocking and reset: single clock clk; rst is asynchronous, active-high.
- Reset values: state = FETCH, retired_count = 0, wait counter = 0, all pulses = 0.
- Outputs are a Moore decode of the state register. Every enable not listed for a state is 0. Defaults: alu_control = ALU_ADD, all selects = 0.
- Reset asserted mid-instruction aborts it immediately with no write strobes. FETCH is entered on the first clk after rst deasserts.
- FETCH: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, PCSource = 00.
  - Exit on access completion (see memory-wait rule below): IRWrite and PCWrite pulse in the completing cycle only, then go to DECODE.
- DECODE: ALUSrcA = 0, ALUSrcB = 11 (branch target precompute). Next state by opcode:
  - ZERO -> R_EXEC if funct is one of ADD/AND/OR/SLT/SUB/XOR.
  - ZERO with funct = ZERO -> FETCH as a NOP; instr_retired pulses.
  - LW or SW -> MEM_ADDR.
  - ADDI, ADDIU or ABS -> I_EXEC.
  - BEQ -> BRANCH.
  - JUMP -> JUMP.
  - Anything else -> ILLEGAL.
- R_EXEC: ALUSrcA = 1, ALUSrcB = 00, alu_control from funct (ALU_ADD/AND/OR/SLT/SUB/XOR), then R_WB.
- R_WB: RegDst = 1, RegWrite = 1, MemToReg = 0; instr_retired pulses; then FETCH.
- I_EXEC: ALUSrcA = 1; ALUSrcB = 10 for ADDI/ADDIU (ALU_ADD); ALUSrcB = 00 with ALU_ABS for ABS. Then I_WB.
- I_WB: RegDst = 0, RegWrite = 1; instr_retired pulses; then FETCH.
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, ALU_ADD. Go to MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: MemRead = 1, IorD = 1; on completion go to MEM_WB.
- MEM_WB: RegDst = 0, MemToReg = 1, RegWrite = 1; instr_retired pulses; then FETCH.
- MEM_WRITE: MemWrite = 1, IorD = 1; on completion instr_retired pulses and go to FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALU_SUB, PCWriteCond = 1, PCSource = 01; instr_retired pulses; then FETCH.
- JUMP: PCWrite = 1, PCSource = 10; instr_retired pulses; then FETCH.
- ILLEGAL: illegal_instr pulses for one cycle, no writes, then FETCH. The instruction is not retired.
- Memory wait (FETCH, MEM_READ, MEM_WRITE):
  - With USE_MEM_READY = 1, an 8-bit wait counter clears on state entry and increments each cycle mem_ready = 0.
  - mem_ready = 1 completes the access in that cycle.
  - If the counter reaches MEM_TIMEOUT without mem_ready, go to BERR. BERR pulses bus_error for one cycle, performs no writes, then returns to FETCH.
  - mem_ready and timeout in the same cycle: mem_ready wins.
  - Strobes (MemRead/MemWrite) stay high for the whole wait.
  - With USE_MEM_READY = 0, every access completes in one cycle.
- retired_count increments on each instr_retired and wraps from all-ones to 0.

Decomposition:
- mips_pkg gains:
  - t_mc_state enum: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, ILLEGAL, BERR.
  - t_alusrcb and t_pcsource encodings.
- Opcode/funct constants and t_alu_opcode are reused from mips_pkg unchanged.
- One sub-module, mc_mem_wait: wait counter, completion and timeout detection.

Test Plan:
- ADD (opcode ZERO, funct ADD), mem_ready tied 1 -> FETCH, DECODE, R_EXEC (ALU_ADD), R_WB (RegDst = 1, RegWrite = 1); 4 cycles; retired_count 0 -> 1.
- LW with mem_ready delayed 3 cycles in MEM_READ -> MemRead held 4 cycles, then MEM_WB with MemToReg = 1 and RegWrite = 1; 5 + 3 = 8 cycles total.
- BEQ, then JUMP -> BRANCH asserts PCWriteCond with PCSource = 01; JUMP asserts PCWrite with PCSource = 10; 3 cycles each; two instr_retired pulses.
- Undefined opcode 6'h3F -> ILLEGAL, illegal_instr pulses once, back to FETCH; retired_count unchanged.
- SW with mem_ready held 0, MEM_TIMEOUT = 16 -> MemWrite high 16 cycles, then BERR with bus_error pulse, then FETCH; no RegWrite at any point.
- rst asserted during MEM_WRITE wait -> same cycle: state = FETCH, MemWrite = 0, retired_count = 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcodes, funct codes, ALU operations and multi-cycle control types.
// Also holds the DECODE-state dispatch helpers used by the multi-cycle controller.
package mips_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'h0,
        ALU_OR  = 4'h1,
        ALU_ADD = 4'h2,
        ALU_XOR = 4'h3,
        ALU_SUB = 4'h6,
        ALU_SLT = 4'h7,
        ALU_ABS = 4'h8
    } t_alu_opcode;

    localparam logic [5:0] OP_ZERO  = 6'h00;
    localparam logic [5:0] OP_JUMP  = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ABS   = 6'h30;

    localparam logic [5:0] FUNCT_ZERO = 6'h00;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEM_ADDR,
        MEM_READ,
        MEM_WB,
        MEM_WRITE,
        R_EXEC,
        R_WB,
        I_EXEC,
        I_WB,
        BRANCH,
        JUMP,
        ILLEGAL,
        BERR
    } t_mc_state;

    typedef enum logic [1:0] {
        SRCB_B     = 2'b00,
        SRCB_FOUR  = 2'b01,
        SRCB_IMM   = 2'b10,
        SRCB_SHIFT = 2'b11
    } t_alusrcb;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } t_pcsource;

    typedef struct packed {
        t_alu_opcode alu;
        t_alusrcb    alusrcb;
        t_pcsource   pcsource;
        logic        alusrca;
        logic        pc_write;
        logic        pc_write_cond;
        logic        iord;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        reg_dst;
        logic        reg_write;
    } t_mc_ctrl;

    function automatic logic is_rfunct(input logic [5:0] funct);
        return funct inside {FUNCT_ADD, FUNCT_AND, FUNCT_OR, FUNCT_SLT, FUNCT_SUB, FUNCT_XOR};
    endfunction

    function automatic t_alu_opcode funct_to_alu(input logic [5:0] funct);
        t_alu_opcode op;
        case (funct)
            FUNCT_AND: op = ALU_AND;
            FUNCT_OR:  op = ALU_OR;
            FUNCT_SLT: op = ALU_SLT;
            FUNCT_SUB: op = ALU_SUB;
            FUNCT_XOR: op = ALU_XOR;
            default:   op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic t_mc_state decode_next(input logic [5:0] op, input logic [5:0] funct);
        t_mc_state nxt;
        case (op)
            OP_ZERO: begin
                if (is_rfunct(funct)) begin
                    nxt = R_EXEC;
                end else if (funct == FUNCT_ZERO) begin
                    nxt = FETCH;
                end else begin
                    nxt = ILLEGAL;
                end
            end
            OP_LW, OP_SW:              nxt = MEM_ADDR;
            OP_ADDI, OP_ADDIU, OP_ABS: nxt = I_EXEC;
            OP_BEQ:                    nxt = BRANCH;
            OP_JUMP:                   nxt = JUMP;
            default:                   nxt = ILLEGAL;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_control_if.sv
// Control bus between the multi-cycle controller and the shared datapath.
// master = controller side, slave = datapath side.
interface mc_control_if;
    import mips_pkg::*;

    logic [5:0]  instruction31_26;
    logic [5:0]  instruction5_0;
    logic        mem_ready;
    t_alu_opcode alu_control;
    logic        PCWrite;
    logic        PCWriteCond;
    logic        IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic        MemToReg;
    logic        RegDst;
    logic        RegWrite;
    logic        ALUSrcA;
    t_alusrcb    ALUSrcB;
    t_pcsource   PCSource;

    modport master (
        input  instruction31_26, instruction5_0, mem_ready,
        output alu_control, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource
    );

    modport slave (
        output instruction31_26, instruction5_0, mem_ready,
        input  alu_control, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource
    );

endinterface

// File: rtl/mc_mem_wait.sv
// Memory-access wait tracker: counts stalled cycles in a memory state and flags
// completion or timeout. The counter is zero whenever the controller is not mid-wait.
module mc_mem_wait #(
    parameter bit          USE_MEM_READY = 1'b1,
    parameter int unsigned MEM_TIMEOUT   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_active,
    input  logic i_mem_ready,
    output logic o_done,
    output logic o_timeout
);

    // Timeout fires on the stalled cycle that would take the count to MEM_TIMEOUT.
    localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] r_cnt;

    always_comb begin
        if (USE_MEM_READY) begin
            o_done    = i_active && i_mem_ready;
            o_timeout = i_active && !i_mem_ready && (r_cnt == LAST_WAIT);
        end else begin
            o_done    = i_active;
            o_timeout = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (i_active && !o_done && !o_timeout) begin
            r_cnt <= r_cnt + 8'd1;
        end else begin
            r_cnt <= 8'd0;
        end
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS main control unit. Selects and strobes are registered from the next
// state; IRWrite/PCWrite in FETCH and some retire pulses are qualified by memory completion.
module mc_control
    import mips_pkg::*;
#(
    parameter bit          USE_MEM_READY = 1'b1,
    parameter int unsigned MEM_TIMEOUT   = 16,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    mc_control_if.master     bus,
    output logic             illegal_instr,
    output logic             bus_error,
    output logic             instr_retired,
    output logic [CNT_W-1:0] retired_count,
    output t_mc_state        state_o
);

    t_mc_state        r_state;
    t_mc_state        w_state_d;
    t_mc_ctrl         r_ctrl;
    logic             r_retire;
    logic             r_illegal;
    logic             r_berr;
    logic [CNT_W-1:0] r_count;
    logic [5:0]       w_op;
    logic [5:0]       w_funct;
    logic             w_mem_active;
    logic             w_done;
    logic             w_timeout;
    logic             w_fetch_done;
    logic             w_retire_now;

    assign w_op         = bus.instruction31_26;
    assign w_funct      = bus.instruction5_0;
    assign w_mem_active = r_state inside {FETCH, MEM_READ, MEM_WRITE};

    mc_mem_wait #(
        .USE_MEM_READY (USE_MEM_READY),
        .MEM_TIMEOUT   (MEM_TIMEOUT)
    ) u_mem_wait (
        .clk         (clk),
        .rst         (rst),
        .i_active    (w_mem_active),
        .i_mem_ready (bus.mem_ready),
        .o_done      (w_done),
        .o_timeout   (w_timeout)
    );

    function automatic t_mc_ctrl ctrl_decode(input t_mc_state st, input logic [5:0] op,
                                             input logic [5:0] funct);
        t_mc_ctrl c;
        c.alu           = ALU_ADD;
        c.alusrcb       = SRCB_B;
        c.pcsource      = PCSRC_ALU;
        c.alusrca       = 1'b0;
        c.pc_write      = 1'b0;
        c.pc_write_cond = 1'b0;
        c.iord          = 1'b0;
        c.mem_read      = 1'b0;
        c.mem_write     = 1'b0;
        c.mem_to_reg    = 1'b0;
        c.reg_dst       = 1'b0;
        c.reg_write     = 1'b0;
        unique case (st)
            FETCH: begin
                c.mem_read = 1'b1;
                c.alusrcb  = SRCB_FOUR;
            end
            DECODE:   c.alusrcb = SRCB_SHIFT;
            R_EXEC: begin
                c.alusrca = 1'b1;
                c.alu     = funct_to_alu(funct);
            end
            R_WB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            I_EXEC: begin
                c.alusrca = 1'b1;
                if (op == OP_ABS) begin
                    c.alu = ALU_ABS;
                end else begin
                    c.alusrcb = SRCB_IMM;
                end
            end
            I_WB:     c.reg_write = 1'b1;
            MEM_ADDR: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
            end
            MEM_READ: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            MEM_WB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            BRANCH: begin
                c.alusrca       = 1'b1;
                c.alu           = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pcsource      = PCSRC_ALUOUT;
            end
            JUMP: begin
                c.pc_write = 1'b1;
                c.pcsource = PCSRC_JUMP;
            end
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            FETCH: begin
                if (w_done) begin
                    w_state_d = DECODE;
                end else if (w_timeout) begin
                    w_state_d = BERR;
                end
            end
            DECODE:   w_state_d = decode_next(w_op, w_funct);
            MEM_ADDR: w_state_d = (w_op == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ: begin
                if (w_done) begin
                    w_state_d = MEM_WB;
                end else if (w_timeout) begin
                    w_state_d = BERR;
                end
            end
            MEM_WRITE: begin
                if (w_done) begin
                    w_state_d = FETCH;
                end else if (w_timeout) begin
                    w_state_d = BERR;
                end
            end
            R_EXEC:   w_state_d = R_WB;
            I_EXEC:   w_state_d = I_WB;
            default:  w_state_d = FETCH;
        endcase
    end

    // Gated by rst so an in-flight completion cannot strobe while reset is held.
    assign w_fetch_done = !rst && (r_state == FETCH) && w_done;
    assign w_retire_now = !rst && (((r_state == MEM_WRITE) && w_done) ||
                                   ((r_state == DECODE) && (w_op == OP_ZERO) &&
                                    (w_funct == FUNCT_ZERO)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= FETCH;
            r_ctrl    <= ctrl_decode(FETCH, OP_ZERO, FUNCT_ZERO);
            r_retire  <= 1'b0;
            r_illegal <= 1'b0;
            r_berr    <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_d;
            r_ctrl    <= ctrl_decode(w_state_d, w_op, w_funct);
            r_retire  <= w_state_d inside {R_WB, I_WB, MEM_WB, BRANCH, JUMP};
            r_illegal <= (w_state_d == ILLEGAL);
            r_berr    <= (w_state_d == BERR);
            if (instr_retired) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign bus.alu_control = r_ctrl.alu;
    assign bus.PCWrite     = r_ctrl.pc_write | w_fetch_done;
    assign bus.PCWriteCond = r_ctrl.pc_write_cond;
    assign bus.IorD        = r_ctrl.iord;
    assign bus.MemRead     = r_ctrl.mem_read;
    assign bus.MemWrite    = r_ctrl.mem_write;
    assign bus.IRWrite     = w_fetch_done;
    assign bus.MemToReg    = r_ctrl.mem_to_reg;
    assign bus.RegDst      = r_ctrl.reg_dst;
    assign bus.RegWrite    = r_ctrl.reg_write;
    assign bus.ALUSrcA     = r_ctrl.alusrca;
    assign bus.ALUSrcB     = r_ctrl.alusrcb;
    assign bus.PCSource    = r_ctrl.pcsource;

    assign illegal_instr = r_illegal;
    assign bus_error     = r_berr;
    assign instr_retired = r_retire | w_retire_now;
    assign retired_count = r_count;
    assign state_o       = r_state;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: directed per-cycle expectations are queued by the
// stimulus process and checked by an independent monitor on the falling edge.
module tb_mc_control;
    import mips_pkg::*;

    localparam int unsigned CNT_W = 32;

    localparam logic [11:0] F_MR   = 12'h001;
    localparam logic [11:0] F_MW   = 12'h002;
    localparam logic [11:0] F_IRW  = 12'h004;
    localparam logic [11:0] F_PCW  = 12'h008;
    localparam logic [11:0] F_PCWC = 12'h010;
    localparam logic [11:0] F_RW   = 12'h020;
    localparam logic [11:0] F_RD   = 12'h040;
    localparam logic [11:0] F_M2R  = 12'h080;
    localparam logic [11:0] F_IORD = 12'h100;
    localparam logic [11:0] F_ILL  = 12'h200;
    localparam logic [11:0] F_BERR = 12'h400;
    localparam logic [11:0] F_RET  = 12'h800;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             illegal_instr;
    logic             bus_error;
    logic             instr_retired;
    logic [CNT_W-1:0] retired_count;
    t_mc_state        state_o;

    mc_control_if bus ();

    mc_control #(
        .USE_MEM_READY (1'b1),
        .MEM_TIMEOUT   (16),
        .CNT_W         (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .illegal_instr (illegal_instr),
        .bus_error     (bus_error),
        .instr_retired (instr_retired),
        .retired_count (retired_count),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        t_mc_state        st;
        t_alu_opcode      alu;
        logic             srca;
        logic [1:0]       srcb;
        logic [1:0]       pcsrc;
        logic [11:0]      fl;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t       q[$];
    int         n_vec = 0;
    int         n_bad = 0;
    logic [5:0] nxt_op = 6'h00;
    logic [5:0] nxt_funct = 6'h00;
    string      tag = "reset";

    // One clock of stimulus plus the response expected during that clock.
    task automatic step(input logic r, input logic rdy, input t_mc_state st,
                        input t_alu_opcode alu, input logic srca, input logic [1:0] srcb,
                        input logic [1:0] pcsrc, input logic [11:0] fl, input int unsigned cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst                  = r;
        bus.mem_ready        = rdy;
        bus.instruction31_26 = nxt_op;
        bus.instruction5_0   = nxt_funct;
        e.name  = tag;
        e.st    = st;
        e.alu   = alu;
        e.srca  = srca;
        e.srcb  = srcb;
        e.pcsrc = pcsrc;
        e.fl    = fl;
        e.cnt   = CNT_W'(cnt);
        q.push_back(e);
    endtask

    task automatic start(input string name, input logic [5:0] op, input logic [5:0] funct);
        tag       = name;
        nxt_op    = op;
        nxt_funct = funct;
    endtask

    task automatic fetch(input logic rdy, input logic [11:0] fl, input int unsigned cnt);
        step(1'b0, rdy, FETCH, ALU_ADD, 1'b0, 2'b01, 2'b00, fl, cnt);
    endtask

    task automatic dec(input logic [11:0] fl, input int unsigned cnt);
        step(1'b0, 1'b0, DECODE, ALU_ADD, 1'b0, 2'b11, 2'b00, fl, cnt);
    endtask

    task automatic mem_addr(input int unsigned cnt);
        step(1'b0, 1'b0, MEM_ADDR, ALU_ADD, 1'b1, 2'b10, 2'b00, 12'h000, cnt);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [11:0] fl;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e  = q.pop_front();
                fl = {instr_retired, bus_error, illegal_instr, bus.IorD, bus.MemToReg,
                      bus.RegDst, bus.RegWrite, bus.PCWriteCond, bus.PCWrite, bus.IRWrite,
                      bus.MemWrite, bus.MemRead};
                n_vec++;
                if (state_o !== e.st || bus.alu_control !== e.alu || bus.ALUSrcA !== e.srca ||
                    2'(bus.ALUSrcB) !== e.srcb || 2'(bus.PCSource) !== e.pcsrc ||
                    fl !== e.fl || retired_count !== e.cnt) begin
                    n_bad++;
                    $display("FAIL %s vec%0d: got st=%s alu=%s srca=%b srcb=%b pcsrc=%b fl=%h cnt=%0d; want st=%s alu=%s srca=%b srcb=%b pcsrc=%b fl=%h cnt=%0d",
                             e.name, n_vec, state_o.name(), bus.alu_control.name(), bus.ALUSrcA,
                             bus.ALUSrcB, bus.PCSource, fl, retired_count, e.st.name(),
                             e.alu.name(), e.srca, e.srcb, e.pcsrc, e.fl, e.cnt);
                end
            end
        end
    end

    initial begin : stimulus
        bus.mem_ready        = 1'b0;
        bus.instruction31_26 = 6'h00;
        bus.instruction5_0   = 6'h00;

        // Reset held with mem_ready high: no IR/PC load may leak out.
        start("reset", OP_ZERO, FUNCT_ADD);
        repeat (2) step(1'b1, 1'b1, FETCH, ALU_ADD, 1'b0, 2'b01, 2'b00, F_MR, 0);

        start("add", OP_ZERO, FUNCT_ADD);
        fetch(1'b1, F_MR | F_IRW | F_PCW, 0);
        dec(12'h000, 0);
        step(1'b0, 1'b0, R_EXEC, ALU_ADD, 1'b1, 2'b00, 2'b00, 12'h000, 0);
        step(1'b0, 1'b0, R_WB, ALU_ADD, 1'b0, 2'b00, 2'b00, F_RW | F_RD | F_RET, 0);

        start("lw_wait3", OP_LW, 6'h00);
        fetch(1'b1, F_MR | F_IRW | F_PCW, 1);
        dec(12'h000, 1);
        mem_addr(1);
        repeat (3) step(1'b0, 1'b0, MEM_READ, ALU_ADD, 1'b0, 2'b00, 2'b00, F_MR | F_IORD, 1);
        step(1'b0, 1'b1, MEM_READ, ALU_ADD, 1'b0, 2'b00, 2'b00, F_MR | F_IORD, 1);
        step(1'b0, 1'b0, MEM_WB, ALU_ADD, 1'b0, 2'b00, 2'b00, F_M2R | F_RW | F_RET, 1);

        start("beq", OP_BEQ, 6'h00);
        fetch(1'b1, F_MR | F_IRW | F_PCW, 2);
        dec(12'h000, 2);
        step(1'b0, 1'b0, BRANCH, ALU_SUB, 1'b1, 2'b00, 2'b01, F_PCWC | F_RET, 2);

        start("jump", OP_JUMP, 6'h00);
        fetch(1'b1, F_MR | F_IRW | F_PCW, 3);
        dec(12'h000, 3);
        step(1'b0, 1'b0, JUMP, ALU_ADD, 1'b0, 2'b00, 2'b10, F_PCW | F_RET, 3);

        start("illegal", 6'h3F, 6'h00);
        fetch(1'b1, F_MR | F_IRW | F_PCW, 4);
        dec(12'h000, 4);
        step(1'b0, 1'b0, ILLEGAL, ALU_ADD, 1'b0, 2'b00, 2'b00, F_ILL, 4);

        start("nop", OP_ZERO, FUNCT_ZERO);
        fetch(1'b1, F_MR | F_IRW | F_PCW, 4);
        dec(F_RET, 4);

        start("abs", OP_ABS, 6'h00);
        fetch(1'b0, F_MR, 5);
        fetch(1'b1, F_MR | F_IRW | F_PCW, 5);
        dec(12'h000, 5);
        step(1'b0, 1'b0, I_EXEC, ALU_ABS, 1'b1, 2'b00, 2'b00, 12'h000, 5);
        step(1'b0, 1'b0, I_WB, ALU_ADD, 1'b0, 2'b00, 2'b00, F_RW | F_RET, 5);

        start("addi", OP_ADDI, 6'h00);
        fetch(1'b1, F_MR | F_IRW | F_PCW, 6);
        dec(12'h000, 6);
        step(1'b0, 1'b0, I_EXEC, ALU_ADD, 1'b1, 2'b10, 2'b00, 12'h000, 6);
        step(1'b0, 1'b0, I_WB, ALU_ADD, 1'b0, 2'b00, 2'b00, F_RW | F_RET, 6);

        start("sub", OP_ZERO, FUNCT_SUB);
        fetch(1'b1, F_MR | F_IRW | F_PCW, 7);
        dec(12'h000, 7);
        step(1'b0, 1'b0, R_EXEC, ALU_SUB, 1'b1, 2'b00, 2'b00, 12'h000, 7);
        step(1'b0, 1'b0, R_WB, ALU_ADD, 1'b0, 2'b00, 2'b00, F_RW | F_RD | F_RET, 7);

        // No mem_ready: 16 stalled MEM_WRITE cycles then a bus error, nothing retired.
        start("sw_timeout", OP_SW, 6'h00);
        fetch(1'b1, F_MR | F_IRW | F_PCW, 8);
        dec(12'h000, 8);
        mem_addr(8);
        repeat (16) step(1'b0, 1'b0, MEM_WRITE, ALU_ADD, 1'b0, 2'b00, 2'b00, F_MW | F_IORD, 8);
        step(1'b0, 1'b0, BERR, ALU_ADD, 1'b0, 2'b00, 2'b00, F_BERR, 8);

        // mem_ready on the very cycle the timeout would fire: access completes.
        start("lw_edge", OP_LW, 6'h00);
        fetch(1'b1, F_MR | F_IRW | F_PCW, 8);
        dec(12'h000, 8);
        mem_addr(8);
        repeat (15) step(1'b0, 1'b0, MEM_READ, ALU_ADD, 1'b0, 2'b00, 2'b00, F_MR | F_IORD, 8);
        step(1'b0, 1'b1, MEM_READ, ALU_ADD, 1'b0, 2'b00, 2'b00, F_MR | F_IORD, 8);
        step(1'b0, 1'b0, MEM_WB, ALU_ADD, 1'b0, 2'b00, 2'b00, F_M2R | F_RW | F_RET, 8);

        start("sw_fast", OP_SW, 6'h00);
        fetch(1'b1, F_MR | F_IRW | F_PCW, 9);
        dec(12'h000, 9);
        mem_addr(9);
        step(1'b0, 1'b1, MEM_WRITE, ALU_ADD, 1'b0, 2'b00, 2'b00, F_MW | F_IORD | F_RET, 9);

        start("sw_reset", OP_SW, 6'h00);
        fetch(1'b1, F_MR | F_IRW | F_PCW, 10);
        dec(12'h000, 10);
        mem_addr(10);
        repeat (2) step(1'b0, 1'b0, MEM_WRITE, ALU_ADD, 1'b0, 2'b00, 2'b00, F_MW | F_IORD, 10);
        tag = "rst_midwait";
        step(1'b1, 1'b0, FETCH, ALU_ADD, 1'b0, 2'b01, 2'b00, F_MR, 0);

        start("add_after_rst", OP_ZERO, FUNCT_ADD);
        fetch(1'b1, F_MR | F_IRW | F_PCW, 0);
        dec(12'h000, 0);
        step(1'b0, 1'b0, R_EXEC, ALU_ADD, 1'b1, 2'b00, 2'b00, 12'h000, 0);
        step(1'b0, 1'b0, R_WB, ALU_ADD, 1'b0, 2'b00, 2'b00, F_RW | F_RD | F_RET, 0);
        fetch(1'b0, F_MR, 1);

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
